// File: rtl/div32_seq.sv
// div32_seq: iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 request, sampled only while busy=0
//   dividend, divisor     operands, captured on the accepting edge
//   busy                  high while a non-zero-divisor division is running
//   done                  one-cycle completion pulse
//   quotient, remainder   results, held until the next completion
//   div_by_zero           qualifies quotient/remainder, updated at completion
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state;
    logic [WIDTH-1:0] r, q, v, r_n, q_n;
    logic [CW-1:0]    count;
    logic             dz_pend;
    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] sub;
    logic             nb;
    // Trial subtract as T + ~{0,V} + 1; the carry out of bit WIDTH is "no borrow".
    always_comb begin
        t   = {r, q[WIDTH-1]};
        sub = {1'b0, t} + {1'b0, ~{1'b0, v}} + (WIDTH+2)'(1);
        nb  = sub[WIDTH+1];
        r_n = nb ? sub[WIDTH-1:0] : t[WIDTH-1:0];
        q_n = {q[WIDTH-2:0], nb};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            v           <= '0;
            count       <= '0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done    <= 1'b0;
            dz_pend <= 1'b0;
            // A zero-divisor request completes one edge after acceptance; q still
            // holds the captured dividend here even if a new request lands now.
            if (dz_pend) begin
                done        <= 1'b1;
                quotient    <= '1;
                remainder   <= q;
                div_by_zero <= 1'b1;
            end
            if (state == IDLE) begin
                if (start) begin
                    r     <= '0;
                    q     <= dividend;
                    v     <= divisor;
                    count <= '0;
                    if (divisor == '0) begin
                        dz_pend <= 1'b1;
                    end else begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
            end else begin
                r     <= r_n;
                q     <= q_n;
                count <= count + 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= q_n;
                    remainder   <= r_n;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule
